// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: bus widths, source encodings and queue entry layouts for the CDB arbiter.
package cdb_arbiter_pkg;
    localparam int NICK_W = 5;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CDB_DEPTH = 4;
    localparam logic NOT_JUMP = 1'b0;
    localparam logic CDB_SRC_EX = 1'b0;
    localparam logic CDB_SRC_SLB = 1'b1;
    typedef struct packed {
        logic [NICK_W-1:0] nick;
        logic [DATA_W-1:0] dt;
        logic              ac;
        logic [ADDR_W-1:0] j_pc;
    } ex_entry_t;
    typedef struct packed {
        logic [NICK_W-1:0] nick;
        logic [DATA_W-1:0] dt;
    } slb_entry_t;
endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: per-source result queue with combinational head and next-count output.
module cdb_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [$clog2(DEPTH+1)-1:0] nxt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop_ok, push_ok;
    always_comb begin
        pop_ok = pop_i && cnt_q != '0;
        // a full queue accepts a push only when its head leaves in the same cycle
        push_ok = push_i && (cnt_q != CW'(DEPTH) || pop_ok);
        cnt_d = flush_i ? '0 : cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
        end else begin
            rd_q <= rd_q + PW'(pop_ok);
            wr_q <= wr_q + PW'(push_ok);
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push_ok) mem_q[wr_q] <= din_i;
    end
    assign head_o = mem_q[rd_q];
    assign count_o = cnt_q;
    assign nxt_o = cnt_d;
    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && !pop_ok && cnt_q == CW'(DEPTH)))
        else $error("cdb_fifo overflow: entry dropped");
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter of EX and SLB results onto the registered CDB broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = CDB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iclr,
    input  logic              iEX_en,
    input  logic [NICK_W-1:0] iEX_nick,
    input  logic [DATA_W-1:0] iEX_dt,
    input  logic              iEX_ac,
    input  logic [ADDR_W-1:0] iEX_j_pc,
    output logic              oEX_full,
    input  logic              iSLB_en,
    input  logic [NICK_W-1:0] iSLB_nick,
    input  logic [DATA_W-1:0] iSLB_dt,
    output logic              oSLB_full,
    output logic              oCDB_en,
    output logic [NICK_W-1:0] oCDB_nick,
    output logic [DATA_W-1:0] oCDB_dt,
    output logic              oCDB_ac,
    output logic [ADDR_W-1:0] oCDB_j_pc,
    output logic              oCDB_src
);
    localparam int CW = $clog2(DEPTH+1);
    ex_entry_t         ex_in, ex_head, ex_win;
    slb_entry_t        slb_in, slb_head, slb_win;
    logic [CW-1:0]     ex_cnt, ex_nxt, slb_cnt, slb_nxt;
    logic              go, ex_in_v, slb_in_v, ex_has, slb_has, ex_cand, slb_cand, win, sel_slb;
    logic              ex_push, ex_pop, slb_push, slb_pop;
    logic              en_q, ac_q, src_q, last_q, ex_full_q, slb_full_q;
    logic [NICK_W-1:0] nick_q;
    logic [DATA_W-1:0] dt_q;
    logic [ADDR_W-1:0] jpc_q;
    assign ex_in = '{nick: iEX_nick, dt: iEX_dt, ac: iEX_ac, j_pc: iEX_j_pc};
    assign slb_in = '{nick: iSLB_nick, dt: iSLB_dt};
    always_comb begin
        go = rdy && !iclr;
        ex_in_v = iEX_en && iEX_nick != '0;
        slb_in_v = iSLB_en && iSLB_nick != '0;
        ex_has = ex_cnt != '0;
        slb_has = slb_cnt != '0;
        ex_cand = ex_has || ex_in_v;
        slb_cand = slb_has || slb_in_v;
        sel_slb = slb_cand && (!ex_cand || last_q == CDB_SRC_EX);
        win = ex_cand || slb_cand;
        // an input bypasses only when its source wins with an empty queue; otherwise it enqueues
        ex_pop = go && win && !sel_slb && ex_has;
        ex_push = go && ex_in_v && (ex_has || sel_slb);
        slb_pop = go && sel_slb && slb_has;
        slb_push = go && slb_in_v && (slb_has || !sel_slb);
        ex_win = ex_has ? ex_head : ex_in;
        slb_win = slb_has ? slb_head : slb_in;
    end
    cdb_fifo #(.W($bits(ex_entry_t)), .DEPTH(DEPTH)) u_ex_q (
        .clk(clk), .rst(rst), .flush_i(rdy && iclr), .push_i(ex_push), .pop_i(ex_pop),
        .din_i(ex_in), .head_o(ex_head), .count_o(ex_cnt), .nxt_o(ex_nxt)
    );
    cdb_fifo #(.W($bits(slb_entry_t)), .DEPTH(DEPTH)) u_slb_q (
        .clk(clk), .rst(rst), .flush_i(rdy && iclr), .push_i(slb_push), .pop_i(slb_pop),
        .din_i(slb_in), .head_o(slb_head), .count_o(slb_cnt), .nxt_o(slb_nxt)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= 1'b0;
            nick_q <= '0;
            dt_q <= '0;
            ac_q <= NOT_JUMP;
            jpc_q <= '0;
            src_q <= CDB_SRC_EX;
            last_q <= CDB_SRC_SLB;
            ex_full_q <= 1'b0;
            slb_full_q <= 1'b0;
        end else if (rdy) begin
            en_q <= go && win;
            last_q <= !go ? CDB_SRC_SLB : win ? (sel_slb ? CDB_SRC_SLB : CDB_SRC_EX) : last_q;
            ex_full_q <= ex_nxt >= CW'(DEPTH-1);
            slb_full_q <= slb_nxt >= CW'(DEPTH-1);
            if (go && win) begin
                nick_q <= sel_slb ? slb_win.nick : ex_win.nick;
                dt_q <= sel_slb ? slb_win.dt : ex_win.dt;
                ac_q <= sel_slb ? NOT_JUMP : ex_win.ac;
                jpc_q <= sel_slb ? '0 : ex_win.j_pc;
                src_q <= sel_slb ? CDB_SRC_SLB : CDB_SRC_EX;
            end
        end
    end
    assign oCDB_en = en_q;
    assign oCDB_nick = nick_q;
    assign oCDB_dt = dt_q;
    assign oCDB_ac = ac_q;
    assign oCDB_j_pc = jpc_q;
    assign oCDB_src = src_q;
    assign oEX_full = ex_full_q;
    assign oSLB_full = slb_full_q;
endmodule
